// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_fetch_pkg;

  localparam int          ILEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ILEN-1:0] pc_next(input logic [ILEN-1:0] pc);
    return pc + ILEN'(INSTR_BYTES);
  endfunction

  function automatic logic [ILEN-1:0] pc_align(input logic [ILEN-1:0] pc);
    return {pc[ILEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bundle: imem request/response, decode handoff and redirect.
interface instr_fetch_unit_if #(
  parameter int W = 32
);
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] Instr;
  logic [W-1:0] instr_pc;
  logic         redirect;
  logic [W-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, Instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, Instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// In-order response queue; head reads as zero while empty, flush wins over push/pop.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full,
  output logic [CW-1:0] count
);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

  // A pop frees the full slot in the same cycle, so push-while-full is legal alongside it.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: sequential PC generation, credit-limited imem requests,
// in-order response queue and redirect flush with stale-response dropping.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int           W        = ILEN,
  parameter int           DEPTH    = 4,
  parameter logic [W-1:0] RESET_PC = RESET_PC_DEFAULT
)(
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [W-1:0]  r_fetch_pc;
  logic [W-1:0]  r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_out_nxt;
  logic          w_credit_ok;
  logic          w_req_fire;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Queued plus outstanding fetches never exceed DEPTH, so every response has a slot.
  assign w_inflight  = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_credit_ok = (w_inflight < DEPTH_C);

  assign bus.imem_req_valid = !rst && !bus.redirect && w_credit_ok;
  assign bus.imem_addr      = r_fetch_pc;

  assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign w_rsp_drop = bus.imem_rsp_valid && (r_drop_cnt != '0);
  assign w_push     = bus.imem_rsp_valid && (r_drop_cnt == '0) && !bus.redirect;
  assign w_pop      = bus.instr_valid && bus.instr_ready && !bus.redirect;

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_req_fire)         w_out_nxt = w_out_nxt + CW'(1);
    if (bus.imem_rsp_valid) w_out_nxt = w_out_nxt - CW'(1);
  end

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.pc    = r_rsp_pc;
    w_push_entry.instr = bus.imem_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (bus.redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= pc_align(bus.redirect_pc);
        r_rsp_pc   <= pc_align(bus.redirect_pc);
        r_drop_cnt <= w_out_nxt;
      end else begin
        if (w_req_fire) r_fetch_pc <= pc_next(r_fetch_pc);
        if (w_rsp_drop)  r_drop_cnt <= r_drop_cnt - CW'(1);
        else if (w_push) r_rsp_pc   <= pc_next(r_rsp_pc);
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (bus.redirect),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  assign bus.instr_valid = !w_empty;
  assign bus.Instr       = w_head.instr;
  assign bus.instr_pc    = w_head.pc;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_full && !w_pop));
      assert (!(bus.imem_rsp_valid && r_outstanding == '0));
      assert (r_outstanding <= CW'(DEPTH));
    end
  end
`endif

endmodule
